arith_unit_pipe: RTL and testbench
==================================

Name: arith_unit_pipe

Overview:
Parametrised successor to the single-function adder DUTs. One block performs ADD, SUB or unsigned MUL on WIDTH-bit operands and returns a 2*WIDTH result over valid/ready handshakes. ADD/SUB use a single-cycle carry-lookahead path. MUL is an iterative shift-add engine that reuses the same CLA. The block sits behind dut_wrapper as a selectable DUT, and the shared bench drives it.

Parameters:
WIDTH, 8, operand width; result is 2*WIDTH; legal range 4..32
CLA_GROUP, 4, carry-lookahead group size in bits; must divide WIDTH+1 rounded up to a group multiple (pad internally)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  operand/op presented
in_ready  output  1  block can accept a new operation
op  input  2  00 ADD, 01 SUB, 10 MUL, 11 reserved
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  2*WIDTH  operation result
carry_out  output  1  ADD carry / SUB borrow; 0 for MUL
op_err  output  1  reserved op was issued

Behaviour:
- Reset (reset low, asynchronous): state IDLE; in_ready=1 once reset releases; out_valid=0, result=0, carry_out=0, op_err=0. Any in-flight operation is discarded.
- Accept: the transfer occurs when in_valid && in_ready at a rising clk edge; a, b and op are captured. in_ready=1 in IDLE, and in DONE when out_ready=1 (back-to-back).
- FSM states:
  - IDLE: on accept, go to CALC for ADD/SUB/reserved, or to MUL for MUL.
  - CALC: one cycle; compute; go to DONE.
  - MUL: iterate WIDTH cycles; go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE, or start the new op directly if accepted in the same cycle.
- Latency: accept edge N gives out_valid at N+2 for ADD/SUB/reserved, and at N+WIDTH+2 for MUL. Throughput is 1 op per 2 cycles for ADD with out_ready held high.
- ADD: result = zero-extended a+b (WIDTH+1 significant bits); carry_out = bit WIDTH of the sum.
- SUB: computed as a + ~b + 1 on the CLA. result = a-b as a 2*WIDTH two's-complement value (upper bits all ones when a<b). carry_out = borrow = (a<b).
- MUL: unsigned.
  - Accumulator {hi[WIDTH:0], lo[WIDTH-1:0]}; hi=0, lo=b.
  - Each cycle: if lo[0], hi = hi + a via the CLA; then shift {hi,lo} right by 1.
  - Down-counter of width clog2(WIDTH) runs WIDTH-1..0.
  - result = {hi[WIDTH-1:0], lo}; carry_out=0.
- Reserved op (11): result=0, carry_out=0, op_err=1. op_err is valid only while out_valid=1.
- Output stability: result, carry_out and op_err are registered. They are held stable while out_valid=1 && out_ready=0. They remain unchanged after the handshake until the next result loads.
- in_valid while busy is not accepted; the producer must hold the operands.
- out_ready high with no valid result is ignored.
- Arithmetic wraps only for SUB low bits. ADD and MUL never overflow 2*WIDTH.

Decomposition:
- Package arith_pkg:
  - op_e enum (OP_ADD, OP_SUB, OP_MUL, OP_RSVD)
  - state_e enum (IDLE, CALC, MUL, DONE)
  - function expected_result(op, a, b) returning {carry, result}, for reuse by benches
- Sub-module cla_adder #(.WIDTH(WIDTH+1), .GROUP(CLA_GROUP)):
  - Ports: x, y, cin -> sum, cout.
  - Purely combinational group-generate/propagate lookahead.
  - Instantiated once and muxed between the ADD/SUB and MUL-accumulate operands.

Test Plan:
- ADD a=255, b=1, out_ready=1 -> result=16'h0100, carry_out=1, out_valid exactly 2 edges after accept and high for 1 cycle.
- SUB a=3, b=5 -> result=16'hFFFE, carry_out=1. SUB a=10, b=4 -> result=16'h0006, carry_out=0.
- MUL a=255, b=255 -> result=16'hFE01, out_valid at accept+10 edges, in_ready=0 throughout. MUL a=0, b=200 -> 0.
- Backpressure: ADD 5+3 with out_ready=0 for 5 cycles -> result=8 held stable, in_valid (MUL 12*12) not accepted. Then out_ready=1 with in_valid=1 in the same cycle -> ADD drained, MUL accepted, result=144 later.
- Reset pulled low on cycle 4 of MUL 100*7 -> out_valid=0 and result=0 immediately (asynchronous). After release, in_ready=1; ADD 127+129 -> 16'h0100, carry_out=1.
- op=11 with a=9, b=9 -> op_err=1, result=0, latency 2; the following ADD 1+1 gives op_err=0, result=2.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared types and a reference helper for the arith_unit_pipe block.
//   op_e              : operation encoding driven on the 2-bit op port
//   state_e           : control FSM states
//   expected_result() : golden {carry, result} for a given op/operands;
//                       operands up to 32 bits, result masked to 2*width bits
package arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        MUL,
        DONE
    } state_e;

    function automatic logic [64:0] expected_result(
        input op_e         op,
        input logic [31:0] a,
        input logic [31:0] b,
        input int          width
    );
        logic [63:0] mask;
        logic [63:0] r;
        logic        c;
        mask = (2 * width >= 64) ? '1 : ((64'd1 << (2 * width)) - 64'd1);
        r    = '0;
        c    = 1'b0;
        case (op)
            OP_ADD: begin
                r = {32'd0, a} + {32'd0, b};
                c = (r >> width) != 64'd0;
            end
            OP_SUB: begin
                r = {32'd0, a} - {32'd0, b};
                c = (a < b);
            end
            OP_MUL:  r = {32'd0, a} * {32'd0, b};
            default: r = '0;
        endcase
        return {c, r & mask};
    endfunction

endpackage

// File: rtl/cla_adder.sv
// Combinational carry-lookahead adder.
//   x, y : WIDTH-bit addends
//   cin  : carry in
//   sum  : WIDTH-bit sum
//   cout : carry out of the top bit
// Bits are split into GROUP-sized blocks. Group generate/propagate terms
// give each block's carry-in directly; inside a block the carry ripples.
// A short final block behaves exactly like one zero-padded to GROUP bits.
module cla_adder #(
    parameter int WIDTH = 9,
    parameter int GROUP = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NG = (WIDTH + GROUP - 1) / GROUP;

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] c;
    logic [NG:0]      gc;
    logic             grp_g;
    logic             grp_p;

    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a
        // default first, so no path can leave it holding (a latch).
        p     = x ^ y;
        g     = x & y;
        gc    = '0;
        gc[0] = cin;
        grp_g = 1'b0;
        grp_p = 1'b1;
        for (int j = 0; j < NG; j++) begin
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int k = 0; k < GROUP; k++) begin
                if (j * GROUP + k < WIDTH) begin
                    grp_g = g[j*GROUP+k] | (p[j*GROUP+k] & grp_g);
                    grp_p = grp_p & p[j*GROUP+k];
                end
            end
            gc[j+1] = grp_g | (grp_p & gc[j]);
        end
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i % GROUP == 0) c[i] = gc[i/GROUP];
            else                c[i] = g[i-1] | (p[i-1] & c[i-1]);
        end
    end

    assign sum  = p ^ c;
    assign cout = gc[NG];

endmodule

// File: rtl/arith_unit_pipe.sv
// ADD / SUB / unsigned MUL unit with valid/ready handshakes on both sides.
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready : operation handshake (op, a, b captured on transfer)
//   op                  : 00 ADD, 01 SUB, 10 MUL, 11 reserved
//   a, b                : WIDTH-bit unsigned operands
//   out_valid/out_ready : result handshake
//   result              : 2*WIDTH-bit result
//   carry_out           : ADD carry / SUB borrow, 0 for MUL
//   op_err              : reserved op issued (meaningful while out_valid)
// One CLA of WIDTH+1 bits is shared: CALC uses it for ADD/SUB, MUL uses it
// for the shift-add accumulate. Every result passes through CALC, which
// loads the output registers, so MUL takes WIDTH iterations plus CALC.
module arith_unit_pipe
    import arith_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CLA_GROUP = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 carry_out,
    output logic                 op_err
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e               state_q,     state_d;
    op_e                  op_q,        op_d;
    logic [WIDTH-1:0]     a_q,         a_d;
    logic [WIDTH-1:0]     b_q,         b_d;
    logic [WIDTH:0]       hi_q,        hi_d;
    logic [WIDTH-1:0]     lo_q,        lo_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic [2*WIDTH-1:0]   result_q,    result_d;
    logic                 carry_q,     carry_d;
    logic                 op_err_q,    op_err_d;
    logic                 out_valid_q, out_valid_d;

    logic [WIDTH:0]       cla_x;
    logic [WIDTH:0]       cla_y;
    logic [WIDTH:0]       cla_sum;
    logic                 cla_cin;
    logic                 cla_cout;
    logic                 accept;

    // A finished result can be drained and a new op taken in the same edge.
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Shared adder operands. SUB is a + ~b + 1 over WIDTH+1 bits, so the
    // top sum bit is the borrow and the sum sign-extends to a - b.
    always_comb begin
        cla_x   = {1'b0, a_q};
        cla_y   = {1'b0, b_q};
        cla_cin = 1'b0;
        if (state_q == MUL) begin
            cla_x = hi_q;
            cla_y = lo_q[0] ? {1'b0, a_q} : '0;
        end else if (op_q == OP_SUB) begin
            cla_y   = {1'b1, ~b_q};
            cla_cin = 1'b1;
        end
    end

    cla_adder #(
        .WIDTH (WIDTH + 1),
        .GROUP (CLA_GROUP)
    ) u_cla (
        .x    (cla_x),
        .y    (cla_y),
        .cin  (cla_cin),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        op_err_d = op_err_q;
        unique case (state_q)
            IDLE, DONE: begin
                if ((state_q == DONE) && out_ready) state_d = IDLE;
                if (accept) begin
                    op_d  = op_e'(op);
                    a_d   = a;
                    b_d   = b;
                    hi_d  = '0;
                    lo_d  = b;
                    cnt_d = CNT_W'(WIDTH - 1);
                    state_d = (op_e'(op) == OP_MUL) ? MUL : CALC;
                end
            end
            CALC: begin
                op_err_d = 1'b0;
                unique case (op_q)
                    OP_ADD: begin
                        result_d = {{(WIDTH-1){1'b0}}, cla_sum};
                        carry_d  = cla_sum[WIDTH];
                    end
                    OP_SUB: begin
                        result_d = {{(WIDTH-1){cla_sum[WIDTH]}}, cla_sum};
                        carry_d  = cla_sum[WIDTH];
                    end
                    OP_MUL: begin
                        result_d = {hi_q[WIDTH-1:0], lo_q};
                        carry_d  = 1'b0;
                    end
                    OP_RSVD: begin
                        result_d = '0;
                        carry_d  = 1'b0;
                        op_err_d = 1'b1;
                    end
                endcase
                state_d = DONE;
            end
            MUL: begin
                // Add (or add zero), then shift {carry, sum, lo} right by one.
                {hi_d, lo_d} = {cla_cout, cla_sum, lo_q[WIDTH-1:1]};
                if (cnt_q == '0) state_d = CALC;
                else             cnt_d   = cnt_q - 1'b1;
            end
        endcase
        out_valid_d = (state_d == DONE);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            op_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            op_err_q    <= op_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry_out = carry_q;
    assign op_err    = op_err_q;

endmodule

// File: tb/tb_arith_unit_pipe.sv
// Directed bench for arith_unit_pipe (WIDTH=8). Inputs are driven and
// outputs observed on the falling clock edge; "latency" counts rising edges
// from the accepting edge to the edge where the result handshake can occur.
module tb_arith_unit_pipe;

    localparam int WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 carry_out;
    logic                 op_err;

    int errors = 0;
    int checks = 0;

    arith_unit_pipe #(.WIDTH(WIDTH), .CLA_GROUP(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        op = o; a = x; b = y; in_valid = 1'b1;
        for (int i = 0; i < 40 && in_ready !== 1'b1; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid; lat = -1 on timeout. rdy_seen records
    // any in_ready while the op was still in flight.
    task automatic wait_out(output int lat, output logic rdy_seen);
        lat = -1; rdy_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) begin
                lat = i + 1;
                break;
            end
            if (in_ready !== 1'b0) rdy_seen = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; op = 2'b00; a = '0; b = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h expected 0000", result); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", carry_out); end
        checks++; if (op_err !== 1'b0) begin errors++; $display("FAIL reset_op_err: got %b expected 0", op_err); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_add();
        int lat; logic rs;
        out_ready = 1'b1;
        issue(2'b00, 8'd255, 8'd1);
        wait_out(lat, rs);
        checks++; if (lat != 2) begin errors++; $display("FAIL add_latency: got %0d expected 2", lat); end
        checks++; if (result !== 16'h0100) begin errors++; $display("FAIL add_result: got %h expected 0100", result); end
        checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL add_carry: got %b expected 1", carry_out); end
        checks++; if (op_err !== 1'b0) begin errors++; $display("FAIL add_op_err: got %b expected 0", op_err); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_valid_one_cycle: got %b expected 0", out_valid); end
    endtask

    task automatic test_sub();
        int lat; logic rs;
        issue(2'b01, 8'd3, 8'd5);
        wait_out(lat, rs);
        checks++; if (result !== 16'hFFFE) begin errors++; $display("FAIL sub_neg_result: got %h expected fffe", result); end
        checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL sub_neg_borrow: got %b expected 1", carry_out); end
        @(negedge clk);
        issue(2'b01, 8'd10, 8'd4);
        wait_out(lat, rs);
        checks++; if (lat != 2) begin errors++; $display("FAIL sub_latency: got %0d expected 2", lat); end
        checks++; if (result !== 16'h0006) begin errors++; $display("FAIL sub_pos_result: got %h expected 0006", result); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL sub_pos_borrow: got %b expected 0", carry_out); end
        @(negedge clk);
    endtask

    task automatic test_mul();
        int lat; logic rs;
        issue(2'b10, 8'd255, 8'd255);
        wait_out(lat, rs);
        checks++; if (lat != 10) begin errors++; $display("FAIL mul_latency: got %0d expected 10", lat); end
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL mul_in_ready_busy: got %b expected 0", rs); end
        checks++; if (result !== 16'hFE01) begin errors++; $display("FAIL mul_max_result: got %h expected fe01", result); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL mul_carry: got %b expected 0", carry_out); end
        @(negedge clk);
        issue(2'b10, 8'd0, 8'd200);
        wait_out(lat, rs);
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL mul_zero_result: got %h expected 0000", result); end
        @(negedge clk);
        issue(2'b10, 8'd13, 8'd11);
        wait_out(lat, rs);
        checks++; if (result !== 16'h008F) begin errors++; $display("FAIL mul_13x11_result: got %h expected 008f", result); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat; logic rs;
        out_ready = 1'b0;
        issue(2'b00, 8'd5, 8'd3);
        wait_out(lat, rs);
        checks++; if (result !== 16'h0008) begin errors++; $display("FAIL bp_result: got %h expected 0008", result); end
        op = 2'b10; a = 8'd12; b = 8'd12; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || result !== 16'h0008) begin errors++; $display("FAIL bp_hold_%0d: got valid=%b result=%h expected 1/0008", i, out_valid, result); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_not_accepted_%0d: got in_ready=%b expected 0", i, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
        checks++; if (result !== 16'h0008) begin errors++; $display("FAIL bp_result_kept: got %h expected 0008", result); end
        wait_out(lat, rs);
        checks++; if (lat != 10) begin errors++; $display("FAIL bp_mul_latency: got %0d expected 10", lat); end
        checks++; if (result !== 16'h0090) begin errors++; $display("FAIL bp_mul_result: got %h expected 0090", result); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mul();
        int lat; logic rs;
        issue(2'b10, 8'd100, 8'd7);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL rst_mid_result: got %h expected 0000", result); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        issue(2'b00, 8'd127, 8'd129);
        wait_out(lat, rs);
        checks++; if (lat != 2) begin errors++; $display("FAIL rst_add_latency: got %0d expected 2", lat); end
        checks++; if (result !== 16'h0100) begin errors++; $display("FAIL rst_add_result: got %h expected 0100", result); end
        checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL rst_add_carry: got %b expected 1", carry_out); end
        @(negedge clk);
    endtask

    task automatic test_reserved();
        int lat; logic rs;
        issue(2'b11, 8'd9, 8'd9);
        wait_out(lat, rs);
        checks++; if (lat != 2) begin errors++; $display("FAIL rsvd_latency: got %0d expected 2", lat); end
        checks++; if (op_err !== 1'b1) begin errors++; $display("FAIL rsvd_op_err: got %b expected 1", op_err); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL rsvd_result: got %h expected 0000", result); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL rsvd_carry: got %b expected 0", carry_out); end
        @(negedge clk);
        issue(2'b00, 8'd1, 8'd1);
        wait_out(lat, rs);
        checks++; if (op_err !== 1'b0) begin errors++; $display("FAIL rsvd_next_op_err: got %b expected 0", op_err); end
        checks++; if (result !== 16'h0002) begin errors++; $display("FAIL rsvd_next_result: got %h expected 0002", result); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        op = 2'b00; a = 8'd1; b = 8'd2; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 8'd4; b = 8'd5;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || result !== 16'h0003) begin errors++; $display("FAIL b2b_first: got valid=%b result=%h expected 1/0003", out_valid, result); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b expected 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || result !== 16'h0009) begin errors++; $display("FAIL b2b_second: got valid=%b result=%h expected 1/0009", out_valid, result); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        test_reserved();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
